spi_slave_if: RTL and testbench

SPI_SLAVE_IF -- requirements
Module: spi_slave_if

---
 rtl/spi_slave_if.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_if.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave with per-pin synchronizers, CPOL/CPHA/LSB-first
// support latched per frame, an 8-bit TX holding register and an RX handshake.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN. When it is defined, a byte that
// completes while RX is still full is dropped and ovr_flag is set.
// SYNC_STAGES must be 2 or 3. Each sck phase must last at least
// SYNC_STAGES+2 clk cycles.
module spi_slave_if #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_en,
  input  logic       cfg_cpol,
  input  logic       cfg_cpha,
  input  logic       cfg_lsbfe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       ovr_flag,
  input  logic       ovr_clr,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe
);

  localparam int unsigned DW = 8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_prev, ss_prev;
  logic                   cpol_l, cpha_l, lsbfe_l;
  logic [DW-1:0]          tx_shift, rx_shift, hold_data, rx_pend;
  logic [2:0]             bit_cnt;
  logic                   skip_shift;
  logic                   done_q;

  logic                   ss_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   tx_bit;
  logic [DW-1:0]          rx_shift_in, tx_load_val;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign ss_fall     = ss_prev & ~ss_s;
  assign lead_edge   = (sck_s != cpol_l) && (sck_prev == cpol_l);
  assign trail_edge  = (sck_s == cpol_l) && (sck_prev != cpol_l);
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge : trail_edge;
  assign rx_shift_in = lsbfe_l ? {mosi_s, rx_shift[DW-1:1]} : {rx_shift[DW-2:0], mosi_s};
  assign tx_bit      = lsbfe_l ? tx_shift[0] : tx_shift[DW-1];
  // An empty holding register sends all ones.
  assign tx_load_val = tx_ready ? 8'hFF : hold_data;

  // Pin synchronizers plus one-cycle-delayed copies for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_s;
      ss_prev   <= ss_s;
    end
  end

  // Frame FSM, shift datapath, TX holding register and pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      lsbfe_l    <= 1'b0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_pend    <= '0;
      hold_data  <= '0;
      tx_ready   <= 1'b1;
      bit_cnt    <= 3'd0;
      skip_shift <= 1'b0;
      done_q     <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      miso_oe <= cfg_en & ~ss_s;
      miso    <= cfg_en & ~ss_s & (state == ACTIVE) & tx_bit;
      case (state)
        IDLE: begin
          if (cfg_en && ss_fall) begin
            state      <= ACTIVE;
            busy       <= 1'b1;
            cpol_l     <= cfg_cpol;
            cpha_l     <= cfg_cpha;
            lsbfe_l    <= cfg_lsbfe;
            tx_shift   <= tx_load_val;
            tx_ready   <= 1'b1;
            bit_cnt    <= 3'd0;
            // With CPHA=1 the first leading edge only presents bit 0 of the byte.
            skip_shift <= cfg_cpha;
          end
        end
        ACTIVE: begin
          if (!cfg_en || ss_s) begin
            state      <= IDLE;
            busy       <= 1'b0;
            bit_cnt    <= 3'd0;
            skip_shift <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= rx_shift_in;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              done_q     <= 1'b1;
              rx_pend    <= rx_shift_in;
              tx_shift   <= tx_load_val;
              tx_ready   <= 1'b1;
              // The next shift edge belongs to the reloaded byte's first bit.
              skip_shift <= 1'b1;
            end
          end else if (shift_edge) begin
            if (skip_shift) begin
              skip_shift <= 1'b0;
            end else begin
              tx_shift <= lsbfe_l ? {1'b1, tx_shift[DW-1:1]} : {tx_shift[DW-2:0], 1'b1};
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A write after a same-cycle load keeps the new byte for the next load.
      if (tx_valid && tx_ready) begin
        tx_ready  <= 1'b0;
        hold_data <= tx_data;
      end
    end
  end

  // RX output register, handshake and overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      if (done_q && rx_valid && !rx_ready) begin
        ovr_flag <= 1'b1;
      end else begin
        if (done_q) begin
          rx_data  <= rx_pend;
          rx_valid <= 1'b1;
        end
        if (ovr_clr) ovr_flag <= 1'b0;
      end
`else
      if (done_q) begin
        rx_data  <= rx_pend;
        rx_valid <= 1'b1;
      end
      // Flag starts at zero and can never be set, so it stays zero.
      ovr_flag <= ovr_flag & ~ovr_clr;
`endif
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed bench for spi_slave_if acting as SPI master at clk/16.
`timescale 1ns/1ps
module tb_spi_slave_if;

  localparam int unsigned HALF = 8;
  localparam int          LAT  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_en = 1'b1, cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsbfe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       busy, ovr_flag;
  logic       ovr_clr = 1'b0;
  logic       sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  logic rv_prev = 1'b0;
  logic [7:0] rise_q[$];

  spi_slave_if #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_cpol(cfg_cpol),
    .cfg_cpha(cfg_cpha), .cfg_lsbfe(cfg_lsbfe), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .ovr_flag(ovr_flag), .ovr_clr(ovr_clr), .sck(sck), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every rx_valid rising edge with its cycle and byte.
  always @(negedge clk) begin
    if (rx_valid && !rv_prev) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
      rise_q.push_back(rx_data);
    end
    rv_prev = rx_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic spi_bit(input logic cpol, input logic cpha, input logic mb,
                         output logic sb, output int s_cyc);
    if (!cpha) begin
      mosi = mb;
      wait_clks(HALF);
      sck = ~cpol; sb = miso; s_cyc = cyc;
      wait_clks(HALF);
      sck = cpol;
    end else begin
      sck = ~cpol; mosi = mb;
      wait_clks(HALF);
      sck = cpol; sb = miso; s_cyc = cyc;
      wait_clks(HALF);
    end
  endtask

  task automatic spi_byte(input logic cpol, input logic cpha, input logic lsb,
                          input logic [7:0] b, output logic [7:0] r, output int s_cyc);
    int idx;
    logic sb;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx = lsb ? i : 7 - i;
      spi_bit(cpol, cpha, b[idx], sb, s_cyc);
      r[idx] = sb;
    end
  endtask

  task automatic frame_start(input logic cpol);
    sck = cpol;
    wait_clks(8);
    ss_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic frame_end();
    wait_clks(HALF);
    ss_n = 1'b1;
    wait_clks(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(3);
    if (tx_ready !== 1'b1) begin $display("FAIL reset_tx_ready got %b exp 1", tx_ready); n_fail++; end
    n_checks++;
    if (rx_valid !== 1'b0) begin $display("FAIL reset_rx_valid got %b exp 0", rx_valid); n_fail++; end
    n_checks++;
    if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data got %h exp 00", rx_data); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", busy); n_fail++; end
    n_checks++;
    if ({miso, miso_oe} !== 2'b00) begin $display("FAIL reset_miso got %b exp 00", {miso, miso_oe}); n_fail++; end
    n_checks++;
    if (ovr_flag !== 1'b0) begin $display("FAIL reset_ovr got %b exp 0", ovr_flag); n_fail++; end
    n_checks++;
    rst_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic test_mode0();
    logic [7:0] got, first;
    int s_cyc, base;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsbfe = 1'b0;
    load_tx(8'hA5);
    if (tx_ready !== 1'b0) begin $display("FAIL m0_hold_full got %b exp 0", tx_ready); n_fail++; end
    n_checks++;
    base = rise_cnt; rise_q.delete();
    frame_start(1'b0);
    if ({busy, miso_oe, tx_ready} !== 3'b111) begin
      $display("FAIL m0_active busy/oe/ready got %b exp 111", {busy, miso_oe, tx_ready}); n_fail++;
    end
    n_checks++;
    spi_byte(1'b0, 1'b0, 1'b0, 8'h3C, got, s_cyc);
    frame_end();
    if (got !== 8'hA5) begin $display("FAIL m0_miso got %h exp a5", got); n_fail++; end
    n_checks++;
    if (rise_cnt - base !== 1) begin $display("FAIL m0_pulses got %0d exp 1", rise_cnt - base); n_fail++; end
    n_checks++;
    first = (rise_q.size() > 0) ? rise_q[0] : 8'h00;
    if (first !== 8'h3C) begin $display("FAIL m0_rx_data got %h exp 3c", first); n_fail++; end
    n_checks++;
    if (rise_cyc - s_cyc !== LAT) begin $display("FAIL m0_latency got %0d exp %0d", rise_cyc - s_cyc, LAT); n_fail++; end
    n_checks++;
    if ({busy, miso_oe, miso} !== 3'b000) begin
      $display("FAIL m0_idle busy/oe/miso got %b exp 000", {busy, miso_oe, miso}); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_modes_lsb();
    logic [7:0] got, last;
    int s_cyc, base;
    logic [1:0] m;
    for (int k = 1; k < 4; k++) begin
      m = 2'(k);
      cfg_cpol = m[1]; cfg_cpha = m[0]; cfg_lsbfe = 1'b1;
      load_tx(8'h81);
      base = rise_cnt; rise_q.delete();
      frame_start(m[1]);
      // Changing config mid-frame must not disturb the latched mode.
      cfg_cpha = ~m[0]; cfg_lsbfe = 1'b0;
      spi_byte(m[1], m[0], 1'b1, 8'h7E, got, s_cyc);
      frame_end();
      if (got !== 8'h81) begin $display("FAIL mode%0d_miso got %h exp 81", k, got); n_fail++; end
      n_checks++;
      last = (rise_q.size() > 0) ? rise_q[rise_q.size()-1] : 8'h00;
      if (last !== 8'h7E || rise_cnt - base !== 1) begin
        $display("FAIL mode%0d_rx got %h x%0d exp 7e x1", k, last, rise_cnt - base); n_fail++;
      end
      n_checks++;
    end
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsbfe = 1'b0;
    sck = 1'b0;
    wait_clks(8);
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2, r1, r2;
    int s_cyc, base;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsbfe = 1'b0;
    base = rise_cnt; rise_q.delete();
    frame_start(1'b0);
    spi_byte(1'b0, 1'b0, 1'b0, 8'h11, g1, s_cyc);
    spi_byte(1'b0, 1'b0, 1'b0, 8'h22, g2, s_cyc);
    frame_end();
    if ({g1, g2} !== 16'hFFFF) begin $display("FAIL b2b_miso got %h %h exp ff ff", g1, g2); n_fail++; end
    n_checks++;
    if (rise_cnt - base !== 2) begin $display("FAIL b2b_pulses got %0d exp 2", rise_cnt - base); n_fail++; end
    n_checks++;
    r1 = (rise_q.size() > 0) ? rise_q[0] : 8'h00;
    r2 = (rise_q.size() > 1) ? rise_q[1] : 8'h00;
    if ({r1, r2} !== 16'h1122) begin $display("FAIL b2b_rx got %h %h exp 11 22", r1, r2); n_fail++; end
    n_checks++;
  endtask

  task automatic test_abort();
    logic [7:0] got, last;
    logic sb;
    int s_cyc, base;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsbfe = 1'b0;
    base = rise_cnt;
    frame_start(1'b0);
    load_tx(8'hC3);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, 1'b0, 1'b1, sb, s_cyc);
    wait_clks(HALF);
    if (busy !== 1'b1) begin $display("FAIL abort_busy_before got %b exp 1", busy); n_fail++; end
    n_checks++;
    ss_n = 1'b1;
    wait_clks(3);
    if (busy !== 1'b0) begin $display("FAIL abort_busy_after got %b exp 0", busy); n_fail++; end
    n_checks++;
    wait_clks(12);
    if (rise_cnt - base !== 0) begin $display("FAIL abort_no_rx got %0d exp 0", rise_cnt - base); n_fail++; end
    n_checks++;
    if (tx_ready !== 1'b0) begin $display("FAIL abort_hold_kept got %b exp 0", tx_ready); n_fail++; end
    n_checks++;
    rise_q.delete();
    frame_start(1'b0);
    spi_byte(1'b0, 1'b0, 1'b0, 8'h96, got, s_cyc);
    frame_end();
    last = (rise_q.size() > 0) ? rise_q[0] : 8'h00;
    if (got !== 8'hC3 || last !== 8'h96) begin
      $display("FAIL abort_next_frame miso %h rx %h exp c3 96", got, last); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_overrun();
    logic [7:0] got;
    int s_cyc, base;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsbfe = 1'b0;
    rx_ready = 1'b0;
    base = rise_cnt;
    frame_start(1'b0);
    spi_byte(1'b0, 1'b0, 1'b0, 8'h55, got, s_cyc);
    spi_byte(1'b0, 1'b0, 1'b0, 8'hAA, got, s_cyc);
    frame_end();
    if (rx_valid !== 1'b1 || rise_cnt - base !== 1) begin
      $display("FAIL ovr_valid got %b x%0d exp 1 x1", rx_valid, rise_cnt - base); n_fail++;
    end
    n_checks++;
`ifdef SPI_SLAVE_OVERRUN_EN
    if (rx_data !== 8'h55 || ovr_flag !== 1'b1) begin
      $display("FAIL ovr_drop got %h/%b exp 55/1", rx_data, ovr_flag); n_fail++;
    end
    n_checks++;
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    if (ovr_flag !== 1'b0 || rx_data !== 8'h55) begin
      $display("FAIL ovr_clear got %b/%h exp 0/55", ovr_flag, rx_data); n_fail++;
    end
    n_checks++;
`else
    if (rx_data !== 8'hAA || ovr_flag !== 1'b0) begin
      $display("FAIL ovr_overwrite got %h/%b exp aa/0", rx_data, ovr_flag); n_fail++;
    end
    n_checks++;
`endif
    rx_ready = 1'b1;
    wait_clks(2);
    if (rx_valid !== 1'b0) begin $display("FAIL ovr_drain got %b exp 0", rx_valid); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid_frame();
    logic sb;
    int s_cyc, base;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsbfe = 1'b0;
    frame_start(1'b0);
    load_tx(8'h5A);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, 1'b1, sb, s_cyc);
    if ({busy, miso_oe, tx_ready} !== 3'b110) begin
      $display("FAIL rstmid_pre got %b exp 110", {busy, miso_oe, tx_ready}); n_fail++;
    end
    n_checks++;
    base = rise_cnt;
    rst_n = 1'b0; ss_n = 1'b1;
    @(negedge clk);
    if ({tx_ready, rx_valid, busy, miso, miso_oe, ovr_flag} !== 6'b100000 || rx_data !== 8'h00) begin
      $display("FAIL rstmid_outputs got %b rx %h exp 100000 rx 00",
               {tx_ready, rx_valid, busy, miso, miso_oe, ovr_flag}, rx_data); n_fail++;
    end
    n_checks++;
    rst_n = 1'b1;
    wait_clks(20);
    if (rise_cnt - base !== 0 || busy !== 1'b0) begin
      $display("FAIL rstmid_abort pulses %0d busy %b exp 0 0", rise_cnt - base, busy); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    wait_clks(1);
    test_reset();
    test_mode0();
    test_modes_lsb();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
